four_bit_mux_arbiter: RTL and testbench

- Two-requester arbiter that shares one 4-bit output channel between requester A and requester B.
- Sequences the 4-bit 2:1 mux select (sel=0 passes A, sel=1 passes B) and runs a valid/ready handshake on the shared output.
- Arbitration is round-robin, with a burst limit so one requester cannot hold the channel indefinitely.
- Sits between two producers (e.g. adder result paths) and a single downstream consumer.

---
 rtl/four_bit_mux_arbiter_pkg.sv | 22 ++
 rtl/four_bit_mux_arbiter_mux.sv | 11 +
 rtl/four_bit_mux_arbiter.sv | 125 ++++++++++++
 tb/tb_four_bit_mux_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/four_bit_mux_arbiter_pkg.sv
// Shared encodings for the two-requester 4-bit channel arbiter.
package four_bit_mux_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = ST_IDLE,
    ARB_GNT_A = ST_GNT_A,
    ARB_GNT_B = ST_GNT_B
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } requester_e;

endpackage

// File: rtl/four_bit_mux_arbiter_mux.sv
// 4-bit 2:1 datapath mux shared by the arbiter: S=0 passes A, S=1 passes B.
module four_bit_mux (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       S,
  output logic [3:0] Y
);

  assign Y = S ? B : A;

endmodule

// File: rtl/four_bit_mux_arbiter.sv
// Round-robin, burst-limited arbiter sharing one 4-bit valid/ready channel between A and B.
// Define ARB_FIXED_PRIORITY_EN to make A win every IDLE tie instead of alternating.
module four_bit_mux_arbiter
  import four_bit_mux_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [3:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [3:0] data_b,
  output logic       ack_b,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       sel,
  output logic       grant_a,
  output logic       grant_b
);

  arb_state_e       state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  requester_e       last_q, last_d;

  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic             burst_done;
  logic             tie_pick_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      sel_q   <= SEL_A;
      cnt_q   <= '0;
      last_q  <= REQ_B;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign xfer       = out_valid & out_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign burst_done = (cnt_inc == CNT_W'(MAX_BURST));

`ifdef ARB_FIXED_PRIORITY_EN
  assign tie_pick_a = 1'b1;
`else
  assign tie_pick_a = (last_q == REQ_B);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (req_a && (!req_b || tie_pick_a)) state_d = ARB_GNT_A;
        else if (req_b)                      state_d = ARB_GNT_B;
      end
      ARB_GNT_A: begin
        if (!req_a) begin
          last_d  = REQ_A;
          state_d = req_b ? ARB_GNT_B : ARB_IDLE;
        end else if (xfer) begin
          if (burst_done) begin
            cnt_d = '0;
            if (req_b) begin
              last_d  = REQ_A;
              state_d = ARB_GNT_B;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ARB_GNT_B: begin
        if (!req_b) begin
          last_d  = REQ_B;
          state_d = req_a ? ARB_GNT_A : ARB_IDLE;
        end else if (xfer) begin
          if (burst_done) begin
            cnt_d = '0;
            if (req_a) begin
              last_d  = REQ_B;
              state_d = ARB_GNT_A;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Any ownership change restarts the burst; sel only moves when a grant is taken.
    if (state_d != state_q) cnt_d = '0;
    if (state_d == ARB_GNT_A) sel_d = SEL_A;
    if (state_d == ARB_GNT_B) sel_d = SEL_B;
  end

  always_comb begin
    grant_a   = (state_q == ARB_GNT_A);
    grant_b   = (state_q == ARB_GNT_B);
    sel       = sel_q;
    out_valid = (grant_a & req_a) | (grant_b & req_b);
    ack_a     = grant_a & req_a & out_ready;
    ack_b     = grant_b & req_b & out_ready;
  end

  four_bit_mux u_mux (
    .A (data_a),
    .B (data_b),
    .S (sel_q),
    .Y (out_data)
  );

endmodule

// File: tb/tb_four_bit_mux_arbiter.sv
// Directed bench for four_bit_mux_arbiter with a per-cycle reference model and literal spot checks.
module tb_four_bit_mux_arbiter;

  localparam int MAX_BURST = 4;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, out_ready;
  logic [3:0] data_a, data_b;
  logic       ack_a, ack_b, out_valid, sel, grant_a, grant_b;
  logic [3:0] out_data;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  always #5 clk = ~clk;

  four_bit_mux_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .grant_a   (grant_a),
    .grant_b   (grant_b)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=A 2=B, beats in current grant, last served, mux select.
  int   m_own, m_cnt, m_last;
  logic m_sel;
  int   o, c, l, other;
  logic s, rx, ry;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own <= 0; m_cnt <= 0; m_last <= 2; m_sel <= 1'b0;
    end else begin
      o = m_own; c = m_cnt; l = m_last; s = m_sel;
      if (o == 0) begin
        if (req_a && req_b) o = FIXED ? 1 : ((l == 2) ? 1 : 2);
        else if (req_a)     o = 1;
        else if (req_b)     o = 2;
        if (o != 0) begin s = (o == 2); c = 0; end
      end else begin
        rx    = (o == 1) ? req_a : req_b;
        ry    = (o == 1) ? req_b : req_a;
        other = 3 - o;
        if (!rx) begin
          l = o; o = ry ? other : 0; c = 0;
          if (o != 0) s = (o == 2);
        end else if (out_ready) begin
          c = c + 1;
          if (c == MAX_BURST) begin
            c = 0;
            if (ry) begin l = o; o = other; s = (o == 2); end
          end
        end
      end
      m_own <= o; m_cnt <= c; m_last <= l; m_sel <= s;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      cmp("m_grant_a",   32'(grant_a),   32'(m_own == 1));
      cmp("m_grant_b",   32'(grant_b),   32'(m_own == 2));
      cmp("m_sel",       32'(sel),       32'(m_sel));
      cmp("m_out_valid", 32'(out_valid), 32'((m_own == 1 && req_a) || (m_own == 2 && req_b)));
      cmp("m_out_data",  32'(out_data),  32'(m_sel ? data_b : data_a));
      cmp("m_ack_a",     32'(ack_a),     32'(m_own == 1 && req_a && out_ready));
      cmp("m_ack_b",     32'(ack_b),     32'(m_own == 2 && req_b && out_ready));
      cmp("m_one_hot",   32'(grant_a & grant_b), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nb, gap;

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = 4'h0; data_b = 4'h0; out_ready = 1'b0;
    tick(); tick();
    run = 1'b1;

    // Reset holds everything idle even with a pending request.
    req_a = 1'b1; data_a = 4'h5; out_ready = 1'b1; #1;
    cmp("rst_grant_a", 32'(grant_a), 32'd0);
    cmp("rst_valid",   32'(out_valid), 32'd0);
    cmp("rst_sel",     32'(sel), 32'd0);
    cmp("rst_ack_a",   32'(ack_a), 32'd0);
    cmp("rst_data",    32'(out_data), 32'h5);
    tick(); reset = 1'b0;
    tick();
    cmp("exit_grant_a", 32'(grant_a), 32'd1);
    cmp("exit_data",    32'(out_data), 32'h5);
    cmp("exit_ack_a",   32'(ack_a), 32'd1);

    // Tie at reset exit: 4 A beats, direct switch to B, 4 B beats, back to A.
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'hC; out_ready = 1'b1;
    tick(); reset = 1'b0;
    nb = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i >= 5 && i <= 8 && ack_b) nb++;
      if (i == 1) cmp("tie_first_a", 32'(grant_a), 32'd1);
      if (i == 4) cmp("tie_a_beat4", 32'(ack_a), 32'd1);
      if (i == 5) begin
        cmp("tie_switch_b",   32'(grant_b), 32'd1);
        cmp("tie_switch_sel", 32'(sel), 32'd1);
        cmp("tie_switch_dat", 32'(out_data), 32'hC);
      end
      if (i == 9) begin
        cmp("tie_back_a",   32'(grant_a), 32'd1);
        cmp("tie_back_sel", 32'(sel), 32'd0);
      end
    end
    cmp("tie_b_beats", 32'(nb), 32'd4);

    // Solo requester B keeps the channel across burst boundaries.
    reset = 1'b1; req_a = 1'b0; req_b = 1'b1; data_b = 4'hA;
    tick(); reset = 1'b0;
    nb = 0; gap = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (ack_b) nb++;
      if (!grant_b) gap++;
    end
    cmp("solo_acks", 32'(nb), 32'd10);
    cmp("solo_gaps", 32'(gap), 32'd0);

    // Backpressure while B waits: count holds at 1, then 3 more beats before the switch.
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 4'h9; data_b = 4'h6; out_ready = 1'b1;
    tick(); reset = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp("bp_ack_a",   32'(ack_a), 32'd0);
      cmp("bp_grant_a", 32'(grant_a), 32'd1);
      cmp("bp_data",    32'(out_data), 32'h9);
      tick();
    end
    out_ready = 1'b1;
    tick(); tick();
    cmp("bp_count_held", 32'(grant_a), 32'd1);
    tick();
    cmp("bp_switch_b", 32'(grant_b), 32'd1);

    // Release to IDLE after 2 beats, then B picked up with one cycle latency.
    reset = 1'b1; req_a = 1'b1; req_b = 1'b0; data_a = 4'h7; out_ready = 1'b1;
    tick(); reset = 1'b0;
    tick(); tick(); tick();
    req_a = 1'b0; #1;
    cmp("rel_valid_low", 32'(out_valid), 32'd0);
    cmp("rel_still_a",   32'(grant_a), 32'd1);
    tick();
    cmp("rel_idle_a",     32'(grant_a), 32'd0);
    cmp("rel_idle_valid", 32'(out_valid), 32'd0);
    req_b = 1'b1; data_b = 4'h2; #1;
    cmp("rel_b_latency", 32'(grant_b), 32'd0);
    tick();
    cmp("rel_grant_b", 32'(grant_b), 32'd1);
    cmp("rel_sel_b",   32'(sel), 32'd1);
    cmp("rel_data_b",  32'(out_data), 32'h2);
    req_b = 1'b0;
    tick();
    cmp("idle_sel_hold", 32'(sel), 32'd1);
    cmp("idle_no_grant", 32'(grant_b), 32'd0);

    // IDLE ties: round-robin alternates A,B,A; fixed priority gives A,A,A.
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    tick(); reset = 1'b0;
    tick();
    cmp("alt1_a", 32'(grant_a), 32'd1);
    req_a = 1'b0; req_b = 1'b0; tick();
    req_a = 1'b1; req_b = 1'b1; tick();
    cmp("alt2_b", 32'(grant_b), FIXED ? 32'd0 : 32'd1);
    cmp("alt2_a", 32'(grant_a), FIXED ? 32'd1 : 32'd0);
    req_a = 1'b0; req_b = 1'b0; tick();
    req_a = 1'b1; req_b = 1'b1; tick();
    cmp("alt3_a", 32'(grant_a), 32'd1);
    req_a = 1'b0; tick();
    cmp("a_release_to_b", 32'(grant_b), 32'd1);
    req_a = 1'b1; req_b = 1'b0; tick();
    cmp("b_release_to_a", 32'(grant_a), 32'd1);

    // Reset mid-burst clears grant and ack immediately.
    tick();
    reset = 1'b1; #1;
    cmp("mid_rst_grant", 32'(grant_a), 32'd0);
    cmp("mid_rst_ack",   32'(ack_a), 32'd0);
    cmp("mid_rst_valid", 32'(out_valid), 32'd0);
    cmp("mid_rst_sel",   32'(sel), 32'd0);
    tick(); reset = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
